// File: rtl/fp32_to_int32_scaled.sv
// fp32_to_int32_scaled: three-stage FP32 -> signed 32-bit fixed point (FRAC_IN fractional bits) with saturation.
// Define FP2INT_RNE_EN for round-to-nearest-even; when it is undefined, results truncate toward zero.
module fp32_to_int32_scaled #(
  parameter int FRAC_IN = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp32_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] int_out,
  output logic        sat_flag
);

  // Left-shift amount applied to the 24-bit significand is exp + K_BIAS.
  localparam logic signed [9:0] K_BIAS = 10'(FRAC_IN - 150);

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic        in_sign;
  logic [7:0]  in_exp;
  logic [22:0] in_man;
  assign in_sign = fp32_in[31];
  assign in_exp  = fp32_in[30:23];
  assign in_man  = fp32_in[22:0];

  logic              s1_valid;
  logic              s1_sign;
  logic              s1_zero;
  logic              s1_nan;
  logic              s1_inf;
  logic [23:0]       s1_sig;
  logic signed [9:0] s1_k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_sig   <= '0;
      s1_k     <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_sign  <= in_sign;
      s1_zero  <= (in_exp == 8'd0);
      s1_nan   <= (in_exp == 8'hFF) && (in_man != 23'd0);
      s1_inf   <= (in_exp == 8'hFF) && (in_man == 23'd0);
      s1_sig   <= {1'b1, in_man};
      s1_k     <= $signed({2'b00, in_exp}) + K_BIAS;
    end
  end

  logic [55:0] align_mag;
  logic        align_ovf;
  logic [9:0]  rshift;
  assign rshift = 10'(-s1_k);

`ifdef FP2INT_RNE_EN
  logic [47:0] align_ext;
  logic        align_guard;
  logic        align_sticky;
`endif

  // Any k >= 9 pushes the value past 2^32, so it only needs an overflow flag.
  always_comb begin
    align_mag = '0;
    align_ovf = 1'b0;
`ifdef FP2INT_RNE_EN
    align_ext    = '0;
    align_guard  = 1'b0;
    align_sticky = 1'b0;
`endif
    if (s1_k >= 10'sd9) begin
      align_ovf = 1'b1;
    end else if (s1_k >= 10'sd0) begin
      align_mag = {32'd0, s1_sig} << s1_k[3:0];
    end else begin
`ifdef FP2INT_RNE_EN
      if (rshift >= 10'd25) begin
        align_sticky = 1'b1;
      end else begin
        align_ext    = {s1_sig, 24'd0} >> rshift;
        align_mag    = {32'd0, align_ext[47:24]};
        align_guard  = align_ext[23];
        align_sticky = |align_ext[22:0];
      end
`else
      align_mag = {32'd0, s1_sig >> rshift};
`endif
    end
  end

  logic        s2_valid;
  logic        s2_sign;
  logic        s2_zero;
  logic        s2_nan;
  logic        s2_inf;
  logic        s2_ovf;
  logic [55:0] s2_mag;
`ifdef FP2INT_RNE_EN
  logic        s2_guard;
  logic        s2_sticky;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_zero   <= 1'b0;
      s2_nan    <= 1'b0;
      s2_inf    <= 1'b0;
      s2_ovf    <= 1'b0;
      s2_mag    <= '0;
`ifdef FP2INT_RNE_EN
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
`endif
    end else if (advance) begin
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_zero   <= s1_zero;
      s2_nan    <= s1_nan;
      s2_inf    <= s1_inf;
      s2_ovf    <= align_ovf;
      s2_mag    <= align_mag;
`ifdef FP2INT_RNE_EN
      s2_guard  <= align_guard;
      s2_sticky <= align_sticky;
`endif
    end
  end

  logic [56:0] rnd_mag;
  logic        mag_over;
  logic [31:0] res_val;
  logic        res_sat;

  // Negative results may reach exactly 2^31 without clamping; positive ones stop at 2^31-1.
  always_comb begin
`ifdef FP2INT_RNE_EN
    rnd_mag = {1'b0, s2_mag} + 57'(s2_guard & (s2_sticky | s2_mag[0]));
`else
    rnd_mag = {1'b0, s2_mag};
`endif
    mag_over = s2_ovf || (s2_sign ? (rnd_mag > 57'h0_8000_0000)
                                  : (rnd_mag > 57'h0_7FFF_FFFF));
    res_val  = '0;
    res_sat  = 1'b0;
    if (s2_nan) begin
      res_sat = 1'b1;
    end else if (s2_inf || (!s2_zero && mag_over)) begin
      res_sat = 1'b1;
      res_val = s2_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (!s2_zero) begin
      res_val = s2_sign ? (-rnd_mag[31:0]) : rnd_mag[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      int_out   <= '0;
      sat_flag  <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        int_out  <= res_val;
        sat_flag <= res_sat;
      end
    end
  end

endmodule

// File: tb/tb_fp32_to_int32_scaled.sv
// tb_fp32_to_int32_scaled: scoreboard bench for the FP32 -> fixed-point converter (FRAC_IN = 7).
// Expected results come from a real-arithmetic reference model; honours FP2INT_RNE_EN like the design.
module tb_fp32_to_int32_scaled;

  localparam int FRAC = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp32_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] int_out;
  logic        sat_flag;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  bit bp_mode = 1'b0;

  typedef struct {
    logic [31:0] op;
    logic [31:0] val;
    logic        sat;
    int          acc_edge;
    bit          chk_lat;
  } exp_t;

  exp_t exp_q[$];

  logic        hold_valid = 1'b0;
  logic [31:0] held_int;
  logic        held_sat;

  fp32_to_int32_scaled #(.FRAC_IN(FRAC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp32_in   (fp32_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .int_out   (int_out),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h required %h", tag, obs, expv);
    end
  endtask

  // Reference: value * 2^FRAC in real arithmetic, then truncate or round half to even.
  function automatic logic [32:0] model(input logic [31:0] v);
    logic   s;
    int     ex;
    real    a;
    real    fl;
    real    scale;
    longint mag;
    s  = v[31];
    ex = int'(v[30:23]);
    if (ex == 0) return 33'd0;
    if (ex == 255) begin
      if (v[22:0] != 23'd0) return {1'b1, 32'h0000_0000};
      return s ? {1'b1, 32'h8000_0000} : {1'b1, 32'h7FFF_FFFF};
    end
    scale = 1.0;
    for (int i = 0; i < (ex - 150 + FRAC); i++) scale = scale * 2.0;
    for (int i = 0; i < (150 - FRAC - ex); i++) scale = scale / 2.0;
    a = real'(int'({1'b1, v[22:0]})) * scale;
    if (a >= 8589934592.0) return s ? {1'b1, 32'h8000_0000} : {1'b1, 32'h7FFF_FFFF};
    fl  = $floor(a);
    mag = longint'(fl);
`ifdef FP2INT_RNE_EN
    begin
      real fr;
      fr = a - fl;
      if (fr > 0.5 || (fr == 0.5 && mag[0])) mag = mag + 1;
    end
`endif
    if (!s && mag > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
    if (s && mag > 64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, 32'(s ? -mag : mag)};
  endfunction

  // Monitor: handshake rule, output hold, scoreboard push on accept and pop on drain.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_valid = 1'b0;
    end else begin
      checkOutput("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      if (hold_valid) begin
        checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("hold_int_out", int_out, held_int);
        checkOutput("hold_sat_flag", {31'd0, sat_flag}, {31'd0, held_sat});
      end
      hold_valid = out_valid && !out_ready;
      held_int   = int_out;
      held_sat   = sat_flag;
      if (in_valid && in_ready) begin
        e.op = fp32_in;
        {e.sat, e.val} = model(fp32_in);
        e.acc_edge = cycle + 1;
        e.chk_lat  = !bp_mode;
        exp_q.push_back(e);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("int_out[%h]", e.op), int_out, e.val);
          checkOutput($sformatf("sat_flag[%h]", e.op), {31'd0, sat_flag}, {31'd0, e.sat});
          if (e.chk_lat)
            checkOutput($sformatf("latency[%h]", e.op), 32'(cycle - e.acc_edge + 1), 32'd3);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the operand.
  task automatic applyStimulus(input logic [31:0] v);
    bit acc = 1'b0;
    in_valid = 1'b1;
    fp32_in  = v;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (bp_mode) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    checkOutput("accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic drainWait();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (bp_mode) out_ready = 1'($urandom_range(0, 1));
    end
    checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] randOperand();
    logic       s;
    logic [7:0] ex;
    logic [22:0] m;
    s  = 1'($urandom_range(0, 1));
    ex = 8'($urandom_range(100, 160));
    m  = 23'($urandom);
    return {s, ex, m};
  endfunction

  initial begin
    logic [31:0] directed [14];
    directed = '{32'h3F80_0000, 32'hBFC0_0000, 32'h3C40_0000, 32'h3B80_0000,
                 32'h3CA0_0000, 32'h4B80_0000, 32'hCB80_0000, 32'h7F80_0000,
                 32'hFF80_0000, 32'h7FC0_0000, 32'h8000_0000, 32'h0000_0001,
                 32'h4AFF_FFFF, 32'hBB80_0001};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    fp32_in   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_int_out", int_out, 32'd0);
    checkOutput("reset_sat_flag", {31'd0, sat_flag}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed operands, back to back with the sink always ready.
    foreach (directed[i]) applyStimulus(directed[i]);
    drainWait();

    // Random operands against a randomly stalling sink.
    bp_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) applyStimulus(32'h7FC0_0000);
      else applyStimulus(randOperand());
    end
    drainWait();
    bp_mode   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Three operands in flight, result held at the output, then an asynchronous reset.
    applyStimulus(32'h3F80_0000);
    applyStimulus(32'h4000_0000);
    applyStimulus(32'h4040_0000);
    out_ready = 1'b0;
    checkOutput("inflight_out_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_reset_int_out", int_out, 32'd0);
    checkOutput("async_reset_sat_flag", {31'd0, sat_flag}, 32'd0);
    checkOutput("async_reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("post_reset_idle", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(32'hBFC0_0000);
    drainWait();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
